// File: rtl/ring_pkg.sv
// Shared constants and seed helper for the ring/Johnson sequencer.
// Mode/direction encodings plus the reset/reload seed function.
package ring_pkg;

  localparam int RING_MAXW = 64;

  localparam logic RING_ONEHOT  = 1'b0;
  localparam logic RING_JOHNSON = 1'b1;

  localparam logic RING_UP   = 1'b0;
  localparam logic RING_DOWN = 1'b1;

  // Seed for a given mode: one-hot puts a single bit at init_pos,
  // Johnson starts from the all-zero code.
  function automatic logic [RING_MAXW-1:0] ring_seed(
    input logic        m,
    input int unsigned width,
    input int unsigned init_pos
  );
    logic [RING_MAXW-1:0] s;
    s = '0;
    if (m == RING_ONEHOT) begin
      if (init_pos < width)
        s[init_pos] = 1'b1;
      else
        s[0] = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/ring_legal_chk.sv
// Legality checker for the sequencer state.
// Ports: count (state), mode (0 one-hot, 1 Johnson) -> illegal.
module ring_legal_chk
  import ring_pkg::*;
#(
  parameter int WIDTH = 15
) (
  input  logic [WIDTH-1:0] count,
  input  logic             mode,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH + 1) + 1;

  logic [CW-1:0] ones;
  logic [CW-1:0] edges;

  // Population count and circular boundary count in one sweep.
  always_comb begin
    ones  = '0;
    edges = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (count[i])
        ones = ones + CW'(1);
      if (count[i] != count[(i + 1) % WIDTH])
        edges = edges + CW'(1);
    end
  end

  // A valid Johnson code is one circular run of ones:
  // no more than two boundaries around the ring.
  always_comb begin
    illegal = 1'b0;
    unique case (1'b1)
      (mode == RING_ONEHOT):  illegal = (ones != CW'(1));
      (mode == RING_JOHNSON): illegal = (edges > CW'(2));
    endcase
  end

endmodule

// File: rtl/ring_sequencer.sv
// Parametrised one-hot ring / Johnson sequencer with load and wrap.
// Ports: clk, rst_n (sync, low), en, dir, mode, load, load_pos -> count, wrap, err.
// Build option: RING_SELF_CORRECT_EN adds illegal-state recovery and err.
module ring_sequencer
  import ring_pkg::*;
#(
  parameter  int WIDTH    = 15,
  parameter  int INIT_POS = WIDTH - 1,
  localparam int PW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [PW-1:0]    load_pos,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] SEED_OH =
    WIDTH'(ring_seed(RING_ONEHOT, WIDTH, INIT_POS));
  localparam logic [WIDTH-1:0] SEED_JC =
    WIDTH'(ring_seed(RING_JOHNSON, WIDTH, INIT_POS));

  localparam logic [PW:0] LIM = (PW + 1)'(WIDTH);

`ifdef RING_SELF_CORRECT_EN
  localparam logic SC = 1'b1;
`else
  localparam logic SC = 1'b0;
`endif

  logic             mode_q;
  logic             mode_d;
  logic [WIDTH-1:0] count_d;
  logic             wrap_d;
  logic             err_d;
  logic             illegal;
  logic [WIDTH-1:0] step_nxt;
  logic             step_wrap;
  logic [WIDTH-1:0] load_val;
  logic             load_ok;
  logic [WIDTH-1:0] onehot_pos;

`ifdef RING_SELF_CORRECT_EN
  ring_legal_chk #(
    .WIDTH(WIDTH)
  ) u_chk (
    .count  (count),
    .mode   (mode_q),
    .illegal(illegal)
  );
`else
  assign illegal = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] seed_of(input logic m);
    return (m == RING_JOHNSON) ? SEED_JC : SEED_OH;
  endfunction

  // Next value for a step. Wrap flags the value that closes a lap:
  // one-hot sees the end bit come around, Johnson returns to zero.
  always_comb begin
    step_nxt  = count;
    step_wrap = 1'b0;
    unique case ({mode_q, dir})
      {RING_ONEHOT, RING_UP}: begin
        step_nxt  = {count[WIDTH-2:0], count[WIDTH-1]};
        step_wrap = count[WIDTH-1];
      end
      {RING_ONEHOT, RING_DOWN}: begin
        step_nxt  = {count[0], count[WIDTH-1:1]};
        step_wrap = count[0];
      end
      {RING_JOHNSON, RING_UP}: begin
        step_nxt  = {count[WIDTH-2:0], ~count[WIDTH-1]};
        step_wrap = (step_nxt == '0);
      end
      {RING_JOHNSON, RING_DOWN}: begin
        step_nxt  = {~count[0], count[WIDTH-1:1]};
        step_wrap = (step_nxt == '0);
      end
    endcase
  end

  // Johnson load fills the lowest load_pos bits.
  always_comb begin
    load_ok    = ({1'b0, load_pos} < LIM);
    onehot_pos = WIDTH'(1) << load_pos;
    load_val   = onehot_pos;
    if (mode_q == RING_JOHNSON)
      load_val = onehot_pos - WIDTH'(1);
  end

  always_comb begin
    count_d = count;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (mode != mode_q) begin
      count_d = seed_of(mode);
      mode_d  = mode;
    end else if (illegal) begin
      count_d = seed_of(mode_q);
      err_d   = 1'b1;
    end else if (load) begin
      if (load_ok)
        count_d = load_val;
      else
        err_d = SC;
    end else if (en) begin
      count_d = step_nxt;
      wrap_d  = step_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= seed_of(mode);
      mode_q <= mode;
      wrap   <= 1'b0;
      err    <= 1'b0;
    end else begin
      count  <= count_d;
      mode_q <= mode_d;
      wrap   <= wrap_d;
      err    <= err_d;
    end
  end

endmodule

// File: tb/tb_ring_sequencer.sv
// Self-checking bench for ring_sequencer (WIDTH=15 and WIDTH=4).
// Vector table through a scoreboard queue plus Johnson/recovery sequences.
module tb_ring_sequencer;

`ifdef RING_SELF_CORRECT_EN
  localparam logic SC = 1'b1;
`else
  localparam logic SC = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        dir;
  logic        mode;
  logic        load;
  logic [3:0]  lp15;
  logic [1:0]  lp4;
  logic [14:0] c15;
  logic        w15;
  logic        e15;
  logic [3:0]  c4;
  logic        w4;
  logic        e4;

  int total;
  int passed;

  ring_sequencer #(.WIDTH(15)) dut15 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .dir     (dir),
    .mode    (mode),
    .load    (load),
    .load_pos(lp15),
    .count   (c15),
    .wrap    (w15),
    .err     (e15)
  );

  ring_sequencer #(.WIDTH(4)) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .dir     (dir),
    .mode    (mode),
    .load    (load),
    .load_pos(lp4),
    .count   (c4),
    .wrap    (w4),
    .err     (e4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        dir;
    logic        mode;
    logic        load;
    logic [3:0]  lp;
    logic [14:0] c;
    logic        w;
    logic        e;
  } vec_t;

  vec_t vt[24];
  vec_t sb[$];

  task automatic check(input string nm, input int idx,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp)
      passed++;
    else
      $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
  endtask

  function automatic vec_t mk(
    input logic r, input logic e, input logic d,
    input logic m, input logic l, input logic [3:0] p,
    input logic [14:0] c, input logic w, input logic er);
    vec_t v;
    v.rst_n = r; v.en = e; v.dir = d; v.mode = m;
    v.load = l; v.lp = p; v.c = c; v.w = w; v.e = er;
    return v;
  endfunction

  logic [3:0] jexp[8];

  initial begin
    vec_t x;
    total  = 0;
    passed = 0;
    rst_n = 1'b0; en = 1'b0; dir = 1'b0;
    mode = 1'b0; load = 1'b0; lp15 = '0; lp4 = '0;

    //       rst en dir mode ld lp  count      w  e
    vt[0]  = mk(0, 1, 0, 0, 1, 5,  15'h4000, 0, 0);
    vt[1]  = mk(1, 1, 0, 0, 0, 0,  15'h0001, 1, 0);
    vt[2]  = mk(1, 1, 0, 0, 0, 0,  15'h0002, 0, 0);
    vt[3]  = mk(1, 0, 0, 0, 0, 0,  15'h0002, 0, 0);
    vt[4]  = mk(1, 1, 1, 0, 0, 0,  15'h0001, 0, 0);
    vt[5]  = mk(1, 1, 1, 0, 0, 0,  15'h4000, 1, 0);
    vt[6]  = mk(1, 1, 0, 0, 0, 0,  15'h0001, 1, 0);
    vt[7]  = mk(1, 1, 1, 0, 0, 0,  15'h4000, 1, 0);
    vt[8]  = mk(1, 1, 0, 0, 0, 0,  15'h0001, 1, 0);
    vt[9]  = mk(1, 1, 0, 0, 1, 5,  15'h0020, 0, 0);
    vt[10] = mk(1, 1, 0, 0, 1, 15, 15'h0020, 0, SC);
    vt[11] = mk(1, 1, 0, 0, 0, 0,  15'h0040, 0, 0);
    vt[12] = mk(1, 1, 0, 1, 0, 0,  15'h0000, 0, 0);
    vt[13] = mk(1, 1, 0, 1, 0, 0,  15'h0001, 0, 0);
    vt[14] = mk(1, 1, 0, 1, 1, 3,  15'h0007, 0, 0);
    vt[15] = mk(1, 1, 1, 1, 0, 0,  15'h0003, 0, 0);
    vt[16] = mk(1, 1, 1, 1, 0, 0,  15'h0001, 0, 0);
    vt[17] = mk(1, 1, 1, 1, 0, 0,  15'h0000, 1, 0);
    vt[18] = mk(1, 1, 1, 1, 0, 0,  15'h4000, 0, 0);
    vt[19] = mk(1, 1, 0, 0, 0, 0,  15'h4000, 0, 0);
    vt[20] = mk(1, 1, 0, 0, 0, 0,  15'h0001, 1, 0);
    vt[21] = mk(0, 1, 0, 0, 1, 5,  15'h4000, 0, 0);
    vt[22] = mk(1, 1, 0, 0, 1, 0,  15'h0001, 0, 0);
    vt[23] = mk(1, 1, 0, 0, 1, 14, 15'h4000, 0, 0);

    jexp[0] = 4'b0001; jexp[1] = 4'b0011;
    jexp[2] = 4'b0111; jexp[3] = 4'b1111;
    jexp[4] = 4'b1110; jexp[5] = 4'b1100;
    jexp[6] = 4'b1000; jexp[7] = 4'b0000;

    repeat (2) @(posedge clk);

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      rst_n = vt[i].rst_n; en = vt[i].en;
      dir = vt[i].dir; mode = vt[i].mode;
      load = vt[i].load; lp15 = vt[i].lp;
      sb.push_back(vt[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb[%0d] got empty want entry", i);
      end else begin
        x = sb.pop_front();
        check("count", i, 32'(c15), 32'(x.c));
        check("wrap", i, 32'(w15), 32'(x.w));
        check("err", i, 32'(e15), 32'(x.e));
      end
    end

    // Johnson, WIDTH=4, from reset.
    @(negedge clk);
    rst_n = 1'b0; mode = 1'b1; en = 1'b0;
    load = 1'b0; dir = 1'b0;
    @(posedge clk); #1;
    check("j4_rst", 0, 32'(c4), 32'(4'b0000));
    check("j4_rstw", 0, 32'(w4), 32'(1'b0));
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("j4_cnt", k, 32'(c4), 32'(jexp[k]));
      check("j4_wrap", k, 32'(w4), 32'(k == 7));
      check("j4_err", k, 32'(e4), 32'(1'b0));
    end

`ifdef RING_SELF_CORRECT_EN
    @(negedge clk);
    en = 1'b0; mode = 1'b0;
    @(posedge clk); #1;
    check("sc_seed", 0, 32'(c15), 32'(15'h4000));
    @(negedge clk);
    force dut15.count = 15'h0003;
    #1;
    release dut15.count;
    @(posedge clk); #1;
    check("sc_cnt", 0, 32'(c15), 32'(15'h4000));
    check("sc_err", 0, 32'(e15), 32'(1'b1));
    @(posedge clk); #1;
    check("sc_cnt", 1, 32'(c15), 32'(15'h4000));
    check("sc_err", 1, 32'(e15), 32'(1'b0));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
